// File: rtl/score_display_sequencer_if.sv
// Score path between the tracker and the three-digit display sequencer.
// The tracker (or a bench) drives the master side; the sequencer is the slave side.
interface score_display_sequencer_if #(
    parameter int SCORE_W = 8
);
    logic               badColl;
    logic [SCORE_W-1:0] curr_score;
    logic [SCORE_W-1:0] high_score;
    logic               game_over;
    logic               score_clr;
    logic [1:0]         digit_sel;
    logic [3:0]         digit_val;
    logic               seg_en;
    logic               conv_busy;

    modport master (
        output badColl, curr_score, high_score,
        input  game_over, score_clr, digit_sel, digit_val, seg_en, conv_busy
    );

    modport slave (
        input  badColl, curr_score, high_score,
        output game_over, score_clr, digit_sel, digit_val, seg_en, conv_busy
    );
endinterface

// File: rtl/score_display_sequencer.sv
// Game-over flash/hold sequencer with a shift-and-add-3 BCD converter and a
// three-digit scan that feeds the multiplexed seven-segment decoders.
module score_display_sequencer #(
    parameter int SCORE_W     = 8,
    parameter int MAX_SCORE   = 140,
    parameter int FLASH_TICKS = 1000000,
    parameter int FLASH_COUNT = 8,
    parameter int HOLD_TICKS  = 2000000
) (
    input logic                        clk,
    input logic                        nRst,
    score_display_sequencer_if.slave   sif
);

    localparam int TICK_MAX = (FLASH_TICKS > HOLD_TICKS) ? FLASH_TICKS : HOLD_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int HALF_W   = $clog2(FLASH_COUNT + 1);
    localparam int CNT_W    = $clog2(SCORE_W + 1);
    localparam int SR_W     = SCORE_W + 12;

    localparam logic [SCORE_W-1:0] MAX_SCORE_V   = SCORE_W'(MAX_SCORE);
    localparam logic [TICK_W-1:0]  FLASH_LAST    = TICK_W'(FLASH_TICKS - 1);
    localparam logic [TICK_W-1:0]  HOLD_LAST     = TICK_W'(HOLD_TICKS - 1);
    localparam logic [HALF_W-1:0]  FLASH_HALVES  = HALF_W'(FLASH_COUNT);
    localparam logic [CNT_W-1:0]   LAST_SHIFT    = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        FLASH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic               score_clr_q, score_clr_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    shift_q, shift_d;
    logic [SCORE_W-1:0] snap_q, snap_d;
    logic [SCORE_W-1:0] last_q, last_d;
    logic [11:0]        bcd_q, bcd_d;
    logic [1:0]         digit_sel_q, digit_sel_d;
    logic [3:0]         digit_val_q, digit_val_d;
    logic               seg_en_q, seg_en_d;
    logic [SCORE_W-1:0] src;

    // One double-dabble step: correct every BCD nibble that would overflow, then shift.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int k = 0; k < 3; k++) begin
            if (r[SCORE_W + 4*k +: 4] >= 4'd5)
                r[SCORE_W + 4*k +: 4] = r[SCORE_W + 4*k +: 4] + 4'd3;
        end
        return r << 1;
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        half_d      = half_q;
        score_clr_d = 1'b0;
        unique case (state_q)
            PLAY: begin
                // curr_score is stale while the tracker is still clearing it
                if (sif.badColl || (!score_clr_q && sif.curr_score >= MAX_SCORE_V)) begin
                    state_d = FLASH;
                    tick_d  = '0;
                    half_d  = '0;
                end
            end
            FLASH: begin
                if (tick_q == FLASH_LAST) begin
                    tick_d = '0;
                    half_d = half_q + HALF_W'(1);
                    if (half_d == FLASH_HALVES) state_d = HOLD;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            HOLD: begin
                if (tick_q == HOLD_LAST) begin
                    state_d     = PLAY;
                    tick_d      = '0;
                    score_clr_d = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = PLAY;
        endcase
    end

    assign src = (state_q == PLAY) ? sif.curr_score : sif.high_score;

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        snap_d  = snap_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        if (busy_q) begin
            shift_d = dabble_step(shift_q);
            cnt_d   = cnt_q + CNT_W'(1);
            // Digits and last value update together so the display never shows a partial result
            if (cnt_q == LAST_SHIFT) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                bcd_d  = shift_d[SR_W-1 -: 12];
                last_d = snap_q;
            end
        end else if (src != last_q) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            shift_d = {12'd0, src};
            snap_d  = src;
        end
    end

    // Scan outputs are computed from next-state values so they line up with digit_sel.
    always_comb begin
        digit_sel_d = (digit_sel_q == 2'd2) ? 2'd0 : digit_sel_q + 2'd1;
        unique case (digit_sel_d)
            2'd0:    digit_val_d = bcd_d[3:0];
            2'd1:    digit_val_d = bcd_d[7:4];
            default: digit_val_d = bcd_d[11:8];
        endcase
        seg_en_d = !((state_d == FLASH) && half_d[0]);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    // NOTE: every register here, including the BCD and snapshot stores, is reset so an abort leaves no stale digits.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= PLAY;
            tick_q      <= '0;
            half_q      <= '0;
            score_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            snap_q      <= '0;
            last_q      <= '0;
            bcd_q       <= '0;
            digit_sel_q <= 2'd0;
            digit_val_q <= 4'd0;
            seg_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            half_q      <= half_d;
            score_clr_q <= score_clr_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            snap_q      <= snap_d;
            last_q      <= last_d;
            bcd_q       <= bcd_d;
            digit_sel_q <= digit_sel_d;
            digit_val_q <= digit_val_d;
            seg_en_q    <= seg_en_d;
        end
    end

    assign sif.game_over = (state_q != PLAY);
    assign sif.score_clr = score_clr_q;
    assign sif.digit_sel = digit_sel_q;
    assign sif.digit_val = digit_val_q;
    assign sif.seg_en    = seg_en_q;
    assign sif.conv_busy = busy_q;

endmodule

// File: tb/tb_score_display_sequencer.sv
// Randomized bench for score_display_sequencer against a cycle-count reference model
// built from plain arithmetic (age of the game-over sequence, decimal digits via / and %).
module tb_score_display_sequencer;

    localparam int SCORE_W   = 8;
    localparam int MAX_SCORE = 140;
    localparam int FT        = 4;
    localparam int FC        = 8;
    localparam int HT        = 10;
    localparam int FLASH_LEN = FT * FC;
    localparam int SEQ_LEN   = FLASH_LEN + HT;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    always #5 clk = ~clk;

    score_display_sequencer_if #(.SCORE_W(SCORE_W)) sif ();

    score_display_sequencer #(
        .SCORE_W    (SCORE_W),
        .MAX_SCORE  (MAX_SCORE),
        .FLASH_TICKS(FT),
        .FLASH_COUNT(FC),
        .HOLD_TICKS (HT)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .sif (sif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: m_age counts cycles since the sequence began.
    int m_over, m_age, m_clr, m_sel, m_disp, m_last, m_busy, m_left, m_snap, m_live;
    int cnt_over, cnt_blank, cnt_clr, cnt_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int digit_of(input int v, input int pos);
        int div;
        div = (pos == 0) ? 1 : (pos == 1) ? 10 : 100;
        return (v / div) % 10;
    endfunction

    task automatic model_reset();
        m_over = 0; m_age = 0; m_clr = 0; m_sel = 0; m_disp = 0;
        m_last = 0; m_busy = 0; m_left = 0; m_snap = 0; m_live = 0;
    endtask

    task automatic model_step();
        int src, cs, nclr;
        cs   = int'(sif.curr_score);
        src  = m_over ? int'(sif.high_score) : cs;
        nclr = 0;
        if (m_busy != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_disp = m_snap;
                m_last = m_snap;
            end
        end else if (src != m_last) begin
            m_busy = 1;
            m_left = SCORE_W;
            m_snap = src;
        end
        if (m_over == 0) begin
            if (sif.badColl || (cs >= MAX_SCORE && m_clr == 0)) begin
                m_over = 1;
                m_age  = 0;
            end
        end else if (m_age == SEQ_LEN - 1) begin
            m_over = 0;
            nclr   = 1;
        end else begin
            m_age++;
        end
        m_clr  = nclr;
        m_sel  = (m_sel + 1) % 3;
        m_live = 1;
    endtask

    function automatic int exp_seg();
        if (m_live == 0) return 0;
        if (m_over != 0 && m_age < FLASH_LEN && ((m_age / FT) % 2) == 1) return 0;
        return 1;
    endfunction

    task automatic compare_all();
        check("game_over", sif.game_over, m_over);
        check("score_clr", sif.score_clr, m_clr);
        check("digit_sel", sif.digit_sel, m_sel);
        check("digit_val", sif.digit_val, digit_of(m_disp, m_sel));
        check("seg_en",    sif.seg_en,    exp_seg());
        check("conv_busy", sif.conv_busy, m_busy);
    endtask

    // One clock: model advances, DUT is sampled at the following negedge.
    task automatic cycle();
        int pending_clr;
        pending_clr = m_clr;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (sif.game_over === 1'b1) cnt_over++;
        if (sif.game_over === 1'b1 && sif.seg_en === 1'b0) cnt_blank++;
        if (sif.score_clr === 1'b1) cnt_clr++;
        if (sif.conv_busy === 1'b1) cnt_busy++;
        // tracker zeroes curr_score on the edge that ends the score_clr cycle
        if (pending_clr == 0 && m_clr != 0) begin
            // score_clr becomes visible this cycle; clear after the next edge
        end else if (pending_clr != 0) begin
            sif.curr_score = '0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_counts();
        cnt_over = 0; cnt_blank = 0; cnt_clr = 0; cnt_busy = 0;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        nRst = 1'b1;
    endtask

    task automatic check_digits(input string tag, input int d0, input int d1, input int d2);
        int want;
        for (int i = 0; i < 3; i++) begin
            cycle();
            want = (m_sel == 0) ? d0 : (m_sel == 1) ? d1 : d2;
            check(tag, sif.digit_val, want);
        end
    endtask

    task automatic pulse_coll();
        sif.badColl = 1'b1;
        cycle();
        sif.badColl = 1'b0;
    endtask

    initial begin
        sif.badColl    = 1'b0;
        sif.curr_score = '0;
        sif.high_score = '0;
        model_reset();
        clear_counts();
        @(negedge clk);
        do_reset();

        // Basic conversion latency and scan order
        sif.curr_score = 8'd37;
        clear_counts();
        run(8);
        check("busy_len_37", cnt_busy, 8);
        check_digits("digits_037", 7, 3, 0);

        // Source change mid-conversion finishes the old snapshot first
        sif.curr_score = 8'd20;
        run(12);
        sif.curr_score = 8'd37;
        run(3);
        sif.curr_score = 8'd38;
        run(5);
        check_digits("digits_037_first", 7, 3, 0);
        run(6);
        check_digits("digits_038_after", 8, 3, 0);

        // Collision starts flash/hold showing the high score
        sif.high_score = 8'd125;
        sif.curr_score = 8'd12;
        run(12);
        clear_counts();
        pulse_coll();
        run(20);
        check_digits("digits_high_125", 5, 2, 1);
        run(40);
        check("seq_len_coll", cnt_over, SEQ_LEN);
        check("blank_cycles", cnt_blank, FLASH_LEN / 2);
        check("clr_pulses", cnt_clr, 1);

        // MAX_SCORE ends the game; a second collision does not restart it
        sif.curr_score = 8'd140;
        clear_counts();
        cycle();
        check("enter_on_max", sif.game_over, 1'b1);
        run(10);
        pulse_coll();
        run(50);
        check("seq_len_max", cnt_over, SEQ_LEN);
        check("clr_pulses_max", cnt_clr, 1);

        // Reset during FLASH while a conversion is running
        sif.high_score = 8'd200;
        sif.curr_score = 8'd50;
        run(12);
        pulse_coll();
        run(3);
        check("busy_before_reset", sif.conv_busy, 1'b1);
        do_reset();
        check_digits("digits_after_reset", 0, 0, 0);
        run(5);
        check_digits("digits_050", 0, 5, 0);

        // Full-scale value converts without overflow
        sif.high_score = 8'd255;
        sif.curr_score = 8'd255;
        run(12);
        check_digits("digits_255", 5, 5, 2);
        run(45);

        // Randomized traffic, including occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 10) sif.curr_score = SCORE_W'($urandom_range(0, 150));
            if ($urandom_range(0, 99) < 2)  sif.high_score = SCORE_W'($urandom_range(0, 255));
            sif.badColl = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle();
            sif.badColl = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
